// File: rtl/run_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_detect_pkg
// Brief    : Shared run_sel encodings and helpers for the dual run detector.
// Revision : 1.0 - initial release
// ============================================================================
package run_detect_pkg;

    localparam logic [1:0] SEL_ANY   = 2'b00;
    localparam logic [1:0] SEL_ONES  = 2'b01;
    localparam logic [1:0] SEL_ZEROS = 2'b10;

    // Width needed to hold a run length that saturates at run_len.
    function automatic int len_w(input int run_len);
        return $clog2(run_len + 1);
    endfunction

    // Value qualifier: reserved encoding 2'b11 behaves like SEL_ANY.
    function automatic logic sel_match(input logic [1:0] sel, input logic val);
        case (sel)
            SEL_ONES:  return val;
            SEL_ZEROS: return ~val;
            default:   return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_detect_shift.sv
`default_nettype none
// ============================================================================
// Module   : run_detect_shift
// Brief    : Run detector built from a RUN_LEN-bit sample history plus a
//            saturating fill count; the newest sample sits in history bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module run_detect_shift
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w,
    input  logic       e,
    input  logic [1:0] run_sel,
    output logic       out
);

    localparam int FILL_W = len_w(RUN_LEN);

    logic [RUN_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               w_full;
    logic               w_uniform;

    // Shift in each enabled sample; the fill count stops once the window is full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (e) begin
            r_hist <= {r_hist[RUN_LEN-2:0], w};
            if (r_fill != FILL_W'(RUN_LEN)) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    // Detect when a full window holds one value, then qualify by run_sel.
    always_comb begin
        w_full    = (r_fill == FILL_W'(RUN_LEN));
        w_uniform = (&r_hist) || (~|r_hist);
        out       = w_full && w_uniform && sel_match(run_sel, r_hist[0]);
    end

endmodule
`default_nettype wire

// File: rtl/run_detect_dual.sv
`default_nettype none
// ============================================================================
// Module   : run_detect_dual
// Brief    : Dual-implementation run-length detector. A shift-register
//            detector and a last-value/run-length counter run in lockstep;
//            any disagreement raises a sticky err flag. Rising edges of the
//            counter detector are tallied in a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module run_detect_dual
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int COUNT_W = 8,
    localparam int LEN_W  = len_w(RUN_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               w,
    input  logic               e,
    input  logic [1:0]         run_sel,
    input  logic               clr_err,
    output logic               out_s,
    output logic               out_c,
    output logic               out_diff,
    output logic               err,
    output logic [COUNT_W-1:0] run_cnt,
    output logic [LEN_W-1:0]   cur_len
);

    localparam logic [LEN_W-1:0] c_len_max = LEN_W'(RUN_LEN);

    logic               r_lv;
    logic [LEN_W-1:0]   r_len;
    logic               r_out_c_prev;
    logic [COUNT_W-1:0] r_run_cnt;
    logic               r_err;

    logic               w_lv_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_out_s;
    logic               w_rise;

    run_detect_shift #(
        .RUN_LEN (RUN_LEN)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .w       (w),
        .e       (e),
        .run_sel (run_sel),
        .out     (w_out_s)
    );

    // Run-length state register; len==0 marks "no sample since reset".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lv  <= 1'b0;
            r_len <= '0;
        end else begin
            r_lv  <= w_lv_nxt;
            r_len <= w_len_nxt;
        end
    end

    // Next-state: extend the run on a repeat, restart it on a new value.
    always_comb begin
        w_lv_nxt  = r_lv;
        w_len_nxt = r_len;
        if (e) begin
            if ((r_len == '0) || (w != r_lv)) begin
                w_lv_nxt  = w;
                w_len_nxt = LEN_W'(1);
            end else if (r_len != c_len_max) begin
                w_len_nxt = r_len + LEN_W'(1);
            end
        end
    end

    assign out_s    = w_out_s;
    assign out_c    = (r_len == c_len_max) && sel_match(run_sel, r_lv);
    assign out_diff = out_s ^ out_c;
    assign w_rise   = out_c && !r_out_c_prev;
    assign err      = r_err;
    assign run_cnt  = r_run_cnt;
    assign cur_len  = r_len;

    // Edge history of out_c tracks every clock so run_sel-induced rises count too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_c_prev <= 1'b0;
            r_run_cnt    <= '0;
        end else begin
            r_out_c_prev <= out_c;
            if (w_rise && (r_run_cnt != '1)) begin
                r_run_cnt <= r_run_cnt + COUNT_W'(1);
            end
        end
    end

    // Sticky mismatch flag; a new mismatch beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (out_diff) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_detect_dual.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_detect_dual
// Brief    : Scoreboard bench for run_detect_dual (RUN_LEN=4, COUNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_detect_dual;
    import run_detect_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w = 1'b0;
    logic       e = 1'b0;
    logic [1:0] run_sel = 2'b00;
    logic       clr_err = 1'b0;
    logic       out_s, out_c, out_diff, err;
    logic [1:0] run_cnt;
    logic [2:0] cur_len;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic       full;
        logic       o;
        logic [7:0] len;
        logic [7:0] cnt;
        logic       er;
    } exp_t;

    exp_t q[$];
    exp_t m_x;

    run_detect_dual #(
        .RUN_LEN (4),
        .COUNT_W (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w        (w),
        .e        (e),
        .run_sel  (run_sel),
        .clr_err  (clr_err),
        .out_s    (out_s),
        .out_c    (out_c),
        .out_diff (out_diff),
        .err      (err),
        .run_cnt  (run_cnt),
        .cur_len  (cur_len)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: each edge that has a queued expectation is checked just after it.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_x = q.pop_front();
            cmp({m_x.name, " out_diff"}, {7'd0, out_diff}, 8'd0);
            cmp({m_x.name, " err"}, {7'd0, err}, {7'd0, m_x.er});
            if (m_x.full) begin
                cmp({m_x.name, " out_s"}, {7'd0, out_s}, {7'd0, m_x.o});
                cmp({m_x.name, " out_c"}, {7'd0, out_c}, {7'd0, m_x.o});
                cmp({m_x.name, " cur_len"}, {5'd0, cur_len}, m_x.len);
                cmp({m_x.name, " run_cnt"}, {6'd0, run_cnt}, m_x.cnt);
            end
        end
    end

    // Drive one edge worth of inputs and queue what must be seen after it.
    task automatic step(input logic r, input logic wv, input logic ev, input logic [1:0] sel,
                        input string nm, input logic o, input logic [7:0] len,
                        input logic [7:0] cnt, input logic er);
        exp_t x;
        @(negedge clk);
        rst_n = r; w = wv; e = ev; run_sel = sel; clr_err = 1'b0;
        x.name = nm; x.full = 1'b1; x.o = o; x.len = len; x.cnt = cnt; x.er = er;
        q.push_back(x);
    endtask

    // Same-cycle check of the combinational outputs after a step's inputs settle.
    task automatic peek(input string nm, input logic o);
        #1;
        cmp({nm, " out_s"}, {7'd0, out_s}, {7'd0, o});
        cmp({nm, " out_c"}, {7'd0, out_c}, {7'd0, o});
    endtask

    task automatic rstep();
        exp_t x;
        @(negedge clk);
        rst_n = 1'b1; w = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1));
        run_sel = 2'($urandom_range(0, 3)); clr_err = 1'b0;
        x.name = "random"; x.full = 1'b0; x.o = 1'b0; x.len = 8'd0; x.cnt = 8'd0; x.er = 1'b0;
        q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset held with w=1, e=1
        repeat (2) step(0, 1, 1, SEL_ANY, "reset", 0, 0, 0, 0);
        // Basic run of four ones; count lags the output by one edge
        step(1, 1, 1, SEL_ANY, "basic1", 0, 1, 0, 0);
        step(1, 1, 1, SEL_ANY, "basic2", 0, 2, 0, 0);
        step(1, 1, 1, SEL_ANY, "basic3", 0, 3, 0, 0);
        step(1, 1, 1, SEL_ANY, "basic4", 1, 4, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, SEL_ANY, "long", 1, 4, 1, 0);
        // Value switch to zeros
        step(1, 0, 1, SEL_ANY, "switch1", 0, 1, 1, 0);
        step(1, 0, 1, SEL_ANY, "switch2", 0, 2, 1, 0);
        step(1, 0, 1, SEL_ANY, "switch3", 0, 3, 1, 0);
        step(1, 0, 1, SEL_ANY, "switch4", 1, 4, 1, 0);
        step(1, 0, 1, SEL_ANY, "switch5", 1, 4, 2, 0);
        // run_sel on a zero run
        step(1, 0, 1, SEL_ONES, "sel01", 0, 4, 2, 0);
        peek("sel01 comb", 0);
        step(1, 0, 1, SEL_ONES, "sel01 hold", 0, 4, 2, 0);
        step(1, 0, 1, SEL_ZEROS, "sel10", 1, 4, 3, 0);
        peek("sel10 comb", 1);
        step(1, 1, 1, 2'b11, "sel11", 0, 1, 3, 0);
        peek("sel11 comb", 1);
        step(1, 1, 1, 2'b11, "sel11 ones", 0, 2, 3, 0);
        // Enable gating: state frozen while w toggles
        for (int i = 0; i < 5; i++) step(1, 1'(i % 2), 0, 2'b11, "gated", 0, 2, 3, 0);
        step(1, 1, 1, 2'b11, "ungate1", 0, 3, 3, 0);
        step(1, 1, 1, 2'b11, "ungate2", 1, 4, 3, 0);
        step(1, 1, 1, SEL_ANY, "ungate3", 1, 4, 3, 0);
        // Further separate runs: counter holds at 3
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++)
                step(1, 1'(r % 2), 1, SEL_ANY, "sat", (i == 3), 8'(i + 1), 3, 0);
        // Reset in the middle of a run
        for (int i = 0; i < 3; i++) step(1, 1, 1, SEL_ANY, "partial", 0, 8'(i + 1), 3, 0);
        step(0, 1, 1, SEL_ANY, "midreset", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, SEL_ANY, "rerun", (i == 3), 8'(i + 1), 0, 0);
        step(1, 1, 1, SEL_ANY, "rerun cnt", 1, 4, 1, 0);
        // Random traffic: implementations must always agree
        repeat (2000) rstep();
        step(0, 1, 1, SEL_ANY, "prereset", 0, 0, 0, 0);
        // Forced mismatch sets err
        @(negedge clk);
        rst_n = 1'b1; w = 1'b1; e = 1'b1; run_sel = SEL_ANY; clr_err = 1'b0;
        force dut.out_s = 1'b1;
        #1 cmp("forced out_diff", {7'd0, out_diff}, 8'd1);
        @(posedge clk); #1 cmp("err set", {7'd0, err}, 8'd1);
        @(negedge clk);
        release dut.out_s;
        #1 cmp("released out_diff", {7'd0, out_diff}, 8'd0);
        @(posedge clk); #1 cmp("err sticky", {7'd0, err}, 8'd1);
        // Set wins over clear on the same edge
        @(negedge clk);
        force dut.out_s = 1'b1;
        clr_err = 1'b1;
        @(posedge clk); #1 cmp("err set beats clear", {7'd0, err}, 8'd1);
        @(negedge clk);
        release dut.out_s;
        @(posedge clk); #1 cmp("err cleared", {7'd0, err}, 8'd0);
        @(negedge clk);
        clr_err = 1'b0;
        cmp("scoreboard drained", 8'(q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
